// File: rtl/bitscan_encoder.sv
// Sequential N-to-log2(N) encoder: accepts a request vector, then emits the
// index of each set bit one handshake at a time, flagging the final code.
module bitscan_encoder #(
  parameter int N         = 4,
  parameter int W         = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         zero_flag
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_next;
  logic [N-1:0] pend, pend_next;
  logic         zero_next;
  logic [W-1:0] sel;
  logic         single;

  // Priority select over the pending bits; the last match in loop order wins.
  always_comb begin
    sel = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) sel = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) sel = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign single = (pend != '0) && ((pend & (pend - ONE)) == '0);

  // All outputs come from registered state; in_ready also sees rst_n so the
  // upstream is held off for the whole reset window.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_code  = sel;
  assign out_last  = (state == SCAN) && single;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next = state;
    pend_next  = pend;
    zero_next  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pend_next  = in_vec;
            state_next = SCAN;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_next[sel] = 1'b0;
          if (single) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        pend_next  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      zero_flag <= zero_next;
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Scoreboard bench for bitscan_encoder: LSB-first and MSB-first instances
// share stimulus; a monitor compares each presented code with a queued model.
module tb_bitscan_encoder;

  typedef struct {
    int code;
    bit last;
  } exp_t;

  typedef enum int {OR_ALWAYS, OR_TOGGLE, OR_RANDOM} or_mode_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       out_ready;

  logic       in_ready_l, out_valid_l, out_last_l, zero_flag_l;
  logic [1:0] out_code_l;
  logic       in_ready_m, out_valid_m, out_last_m, zero_flag_m;
  logic [1:0] out_code_m;

  exp_t     q_lsb[$];
  exp_t     q_msb[$];
  or_mode_t or_mode;
  int       n_checks;
  int       n_fail;
  bit       cur_idle;
  bit       zf_req;
  bit       zf_exp;
  bit       after_reset;

  bitscan_encoder #(.N(4), .W(2), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_code(out_code_l), .out_last(out_last_l), .zero_flag(zero_flag_l)
  );

  bitscan_encoder #(.N(4), .W(2), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_code(out_code_m), .out_last(out_last_m), .zero_flag(zero_flag_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: got no expected entry, expected one queued", name, $time);
  endtask

  // Reference: the set-bit indices in ascending order, reversed for MSB-first.
  task automatic push_model(input logic [3:0] v);
    int idx[$];
    for (int i = 0; i < 4; i++) if (v[i]) idx.push_back(i);
    if (idx.size() == 0) zf_req = 1'b1;
    for (int k = 0; k < idx.size(); k++) begin
      q_lsb.push_back('{code: idx[k], last: (k == idx.size() - 1)});
      q_msb.push_back('{code: idx[idx.size() - 1 - k], last: (k == idx.size() - 1)});
    end
  endtask

  // Present a vector at a falling edge and hold it until the model is idle.
  task automatic send(input logic [3:0] v);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = v;
    while (!(q_lsb.size() == 0 && rst_n)) begin
      budget++;
      if (budget > 200) begin
        check("send_timeout", budget, 200);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    push_model(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_q(input int level);
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (q_lsb.size() > level && budget <= 200);
    if (budget > 200) check("drain_timeout", q_lsb.size(), level);
  endtask

  initial begin : ready_drive
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        OR_TOGGLE: out_ready = ~out_ready;
        OR_RANDOM: out_ready = ($urandom_range(0, 3) != 0);
        default:   out_ready = 1'b1;
      endcase
    end
  end

  // Samples just before each rising edge; a handshake seen here completes
  // at that edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #4;
      check("in_ready_lsb", in_ready_l, int'(rst_n && cur_idle));
      check("in_ready_msb", in_ready_m, int'(rst_n && cur_idle));
      check("out_valid_lsb", out_valid_l, int'(!cur_idle));
      check("out_valid_msb", out_valid_m, int'(!cur_idle));
      check("zero_flag_lsb", zero_flag_l, int'(zf_exp));
      check("zero_flag_msb", zero_flag_m, int'(zf_exp));
      if (after_reset) begin
        check("reset_code_lsb", out_code_l, 0);
        check("reset_last_lsb", out_last_l, 0);
        check("reset_code_msb", out_code_m, 0);
      end
      if (!cur_idle && rst_n) begin
        if (q_lsb.size() == 0 || q_msb.size() == 0) begin
          fail_now("scoreboard_underflow");
        end else begin
          check("code_lsb", out_code_l, q_lsb[0].code);
          check("last_lsb", out_last_l, int'(q_lsb[0].last));
          check("code_msb", out_code_m, q_msb[0].code);
          check("last_msb", out_last_m, int'(q_msb[0].last));
          if (out_ready) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
          end
        end
      end
      after_reset = !rst_n;
      if (!rst_n) begin
        q_lsb.delete();
        q_msb.delete();
      end
      zf_exp   = rst_n ? zf_req : 1'b0;
      zf_req   = 1'b0;
      cur_idle = !rst_n || (q_lsb.size() == 0);
    end
  end

  initial begin : stimulus
    n_checks    = 0;
    n_fail      = 0;
    cur_idle    = 1'b1;
    zf_req      = 1'b0;
    zf_exp      = 1'b0;
    after_reset = 1'b0;
    or_mode     = OR_ALWAYS;
    in_valid    = 1'b0;
    in_vec      = '0;
    rst_n       = 1'b0;
    idle(3);
    rst_n = 1'b1;

    send(4'b0101);
    wait_q(0);
    or_mode = OR_TOGGLE;
    send(4'b1111);
    wait_q(0);
    or_mode = OR_ALWAYS;
    send(4'b0000);
    idle(3);
    send(4'b1010);
    wait_q(0);

    // Reset after the first code of a three-bit vector.
    send(4'b1110);
    wait_q(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // The second vector is held during the first scan and taken afterwards.
    send(4'b0011);
    send(4'b1000);
    wait_q(0);
    send(4'b0001);
    wait_q(0);

    or_mode = OR_RANDOM;
    repeat (80) begin
      send(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_q(0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
